// File: rtl/maxpool2x2_flatten_if.sv
// Handshake and data bundle for the 2x2 max-pool / flatten stage.
// The controller drives start/in_map; the pooling block returns busy/done/out_vec.
interface maxpool2x2_flatten_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_H       = 28,
  parameter int IN_W       = 28
);
  localparam int OUT_LEN = CHANNELS * (IN_H / 2) * (IN_W / 2);

  logic                         start;
  logic                         busy;
  logic                         done;
  logic signed [DATA_WIDTH-1:0] in_map  [CHANNELS][IN_H][IN_W];
  logic signed [DATA_WIDTH-1:0] out_vec [OUT_LEN];

  modport master (output start, output in_map, input busy, input done, input out_vec);
  modport slave  (input start, input in_map, output busy, output done, output out_vec);
endinterface

// File: rtl/maxpool2x2_flatten.sv
// 2x2 stride-2 max-pooling stage producing a channel-major flattened vector,
// one pooled element per clock, with a start/busy/done handshake.
module maxpool2x2_flatten #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_H       = 28,
  parameter int IN_W       = 28,
  parameter bit RELU_EN    = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  maxpool2x2_flatten_if.slave bus
);
  localparam int OUT_H   = IN_H / 2;
  localparam int OUT_W   = IN_W / 2;
  localparam int OUT_LEN = CHANNELS * OUT_H * OUT_W;
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW      = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int KW      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int HW      = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int WW      = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int IW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(OUT_H - 1);
  localparam logic [KW-1:0] K_LAST = KW'(OUT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POOL   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                c_q, c_d;
  logic [RW-1:0]                r_q, r_d;
  logic [KW-1:0]                k_q, k_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         wr_en_s;
  logic [IW-1:0]                wr_idx_s;
  logic [HW-1:0]                row0_s, row1_s;
  logic [WW-1:0]                col0_s, col1_s;
  logic signed [DATA_WIDTH-1:0] max_s;
  logic signed [DATA_WIDTH-1:0] pool_s;
  logic signed [DATA_WIDTH-1:0] out_q [OUT_LEN];

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Window addressing and signed max of the four samples; an odd last row/column is never addressed.
  always_comb begin
    row0_s   = HW'(2 * int'(r_q));
    row1_s   = HW'(2 * int'(r_q) + 1);
    col0_s   = WW'(2 * int'(k_q));
    col1_s   = WW'(2 * int'(k_q) + 1);
    max_s    = smax(smax(bus.in_map[c_q][row0_s][col0_s], bus.in_map[c_q][row0_s][col1_s]),
                    smax(bus.in_map[c_q][row1_s][col0_s], bus.in_map[c_q][row1_s][col1_s]));
    wr_idx_s = IW'(int'(c_q) * OUT_H * OUT_W + int'(r_q) * OUT_W + int'(k_q));
  end

  assign pool_s = (RELU_EN && max_s[DATA_WIDTH-1]) ? '0 : max_s;

  // Next-state, counter advance (k fastest, then r, then c) and handshake outputs.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    k_d     = k_q;
    done_d  = 1'b0;
    wr_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          c_d     = '0;
          r_d     = '0;
          k_d     = '0;
          state_d = ST_POOL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POOL: begin
        wr_en_s = 1'b1;
        if (k_q == K_LAST) begin
          k_d = '0;
          if (r_q == R_LAST) begin
            r_d = '0;
            if (c_q == C_LAST) begin
              c_d     = '0;
              state_d = ST_FINISH;
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            r_d = r_q + RW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_POOL) || (state_d == ST_FINISH);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Output vector storage; entries not yet rewritten keep their previous pass value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUT_LEN; i++) begin
        out_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      out_q[wr_idx_s] <= pool_s;
    end else begin
      out_q <= out_q;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.out_vec = out_q;
endmodule
